// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: APB master that drives a CoreSPI register file through one complete
// master-mode SPI burst of 1-256 bytes. It enables and configures the core, clears
// both FIFOs and asserts slave select. It then moves one byte at a time (TXDATA write,
// STATUS poll, RXDATA read) and finally deselects the slave.
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to bound the number of STATUS polls per
// byte to POLL_LIMIT. On timeout err is raised and the burst is closed with a deselect.
//
// Ports:
//   pclk, aresetn          clock, asynchronous active-low reset
//   start, len, ssel_mask  burst request; len 0 means 256 bytes
//   tx_data/valid/ready    byte stream in (ready is combinational in TX_WAIT)
//   rx_data/valid/ready    byte stream out (valid held until ready)
//   busy, done, err        burst status
//   m_paddr .. m_prdata    APB master port to CoreSPI
`timescale 1ns/1ps

module spi_xfer_seq #(
    parameter int unsigned APB_DWIDTH = 8,
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic                  pclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [7:0]            len,
    input  logic [7:0]            ssel_mask,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [6:0]            m_paddr,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [APB_DWIDTH-1:0] m_pwdata,
    input  logic [APB_DWIDTH-1:0] m_prdata
);

    localparam logic [6:0] AddrCtrl1  = 7'h00;
    localparam logic [6:0] AddrRxData = 7'h08;
    localparam logic [6:0] AddrTxData = 7'h0C;
    localparam logic [6:0] AddrCmd    = 7'h1C;
    localparam logic [6:0] AddrStatus = 7'h20;
    localparam logic [6:0] AddrSsel   = 7'h24;

    typedef enum logic [3:0] {
        StIdle,
        StWCtrl,
        StWClr,
        StWSsel,
        StTxWait,
        StWTx,
        StPoll,
        StRRx,
        StRxOut,
        StWDesel,
        StDone
    } state_e;

    state_e     state_q;
    logic [8:0] cnt_q;
    logic [7:0] ssel_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic [7:0] poll_cnt_q;
`endif

    // Byte value zero-extended to the bus width.
    function automatic logic [APB_DWIDTH-1:0] pad(input logic [7:0] b);
        logic [APB_DWIDTH-1:0] w;
        w      = '0;
        w[7:0] = b;
        return w;
    endfunction

    assign tx_ready = (state_q == StTxWait) && tx_valid;

    // Upper read-data bits carry nothing; POLL_LIMIT is inert without the timeout.
    logic unused_sig;
    assign unused_sig = ^{m_prdata, POLL_LIMIT != 32'd0};

    // Every APB state spends one setup cycle (penable=0) and one access cycle
    // (penable=1). The bus controls for the next state are loaded on the access cycle,
    // so back-to-back transfers keep psel high.
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ssel_q     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            m_paddr    <= '0;
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            m_pwrite   <= 1'b0;
            m_pwdata   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (m_psel && !m_penable) begin
                m_penable <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        cnt_q     <= (len == 8'd0) ? 9'd256 : {1'b0, len};
                        ssel_q    <= ssel_mask;
                        state_q   <= StWCtrl;
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        m_paddr   <= AddrCtrl1;
                        m_pwrite  <= 1'b1;
                        m_pwdata  <= pad(8'h03);
                    end
                end
                StWCtrl: begin
                    if (m_penable) begin
                        state_q   <= StWClr;
                        m_penable <= 1'b0;
                        m_paddr   <= AddrCmd;
                        m_pwdata  <= pad(8'h03);
                    end
                end
                StWClr: begin
                    if (m_penable) begin
                        state_q   <= StWSsel;
                        m_penable <= 1'b0;
                        m_paddr   <= AddrSsel;
                        m_pwdata  <= pad(ssel_q);
                    end
                end
                StWSsel: begin
                    if (m_penable) begin
                        state_q   <= StTxWait;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b0;
                    end
                end
                StTxWait: begin
                    if (tx_valid) begin
                        state_q    <= StWTx;
                        m_psel     <= 1'b1;
                        m_penable  <= 1'b0;
                        m_paddr    <= AddrTxData;
                        m_pwrite   <= 1'b1;
                        m_pwdata   <= pad(tx_data);
`ifdef SPI_SEQ_TIMEOUT_EN
                        poll_cnt_q <= '0;
`endif
                    end
                end
                StWTx: begin
                    if (m_penable) begin
                        state_q   <= StPoll;
                        m_penable <= 1'b0;
                        m_paddr   <= AddrStatus;
                        m_pwrite  <= 1'b0;
                    end
                end
                StPoll: begin
                    if (m_penable) begin
                        m_penable <= 1'b0;
                        if (m_prdata[2]) begin
                            // RX FIFO still empty.
`ifdef SPI_SEQ_TIMEOUT_EN
                            if (({24'd0, poll_cnt_q} + 32'd1) >= POLL_LIMIT) begin
                                err      <= 1'b1;
                                state_q  <= StWDesel;
                                m_paddr  <= AddrSsel;
                                m_pwrite <= 1'b1;
                                m_pwdata <= pad(8'h00);
                            end else begin
                                poll_cnt_q <= poll_cnt_q + 8'd1;
                            end
`endif
                        end else begin
                            state_q <= StRRx;
                            m_paddr <= AddrRxData;
                        end
                    end
                end
                StRRx: begin
                    if (m_penable) begin
                        rx_data   <= m_prdata[7:0];
                        rx_valid  <= 1'b1;
                        state_q   <= StRxOut;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                    end
                end
                StRxOut: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        cnt_q    <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            state_q   <= StWDesel;
                            m_psel    <= 1'b1;
                            m_penable <= 1'b0;
                            m_paddr   <= AddrSsel;
                            m_pwrite  <= 1'b1;
                            m_pwdata  <= pad(8'h00);
                        end else begin
                            state_q <= StTxWait;
                        end
                    end
                end
                StWDesel: begin
                    if (m_penable) begin
                        state_q   <= StDone;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: scoreboard bench for spi_xfer_seq. The expected APB transfer list
// doubles as the slave model (read entries carry the data returned on m_prdata).
`timescale 1ns/1ps

module tb_spi_xfer_seq;

    localparam int unsigned PollLimit = 4;

    logic       pclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] ssel_mask = 8'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy, done, err;
    logic [6:0] m_paddr;
    logic       m_psel, m_penable, m_pwrite;
    logic [7:0] m_pwdata;
    logic [7:0] m_prdata = 8'd0;

    spi_xfer_seq #(
        .APB_DWIDTH(8),
        .POLL_LIMIT(PollLimit)
    ) dut (
        .pclk      (pclk),
        .aresetn   (aresetn),
        .start     (start),
        .len       (len),
        .ssel_mask (ssel_mask),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [6:0] addr;
        logic       wr;
        logic [7:0] data;
    } apb_t;

    apb_t       apb_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    bit         tx_hs = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor / slave model, sampled on the falling edge.
    initial begin
        apb_t e;
        forever begin
            @(negedge pclk);
            if (m_psel && !m_penable) begin
                m_prdata = (apb_q.size() != 0) ? apb_q[0].data : 8'h00;
            end
            if (m_psel && m_penable) begin
                check("apb_expected", apb_q.size() != 0, 1);
                if (apb_q.size() != 0) begin
                    e = apb_q.pop_front();
                    check("apb_addr", m_paddr, e.addr);
                    check("apb_write", m_pwrite, e.wr);
                    if (e.wr) check("apb_wdata", m_pwdata, e.data);
                end
            end
            if (rx_valid && rx_ready) begin
                check("rx_expected", rx_q.size() != 0, 1);
                if (rx_q.size() != 0) check("rx_data", rx_data, rx_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
            end
            tx_hs = tx_valid && tx_ready;
        end
    end

    // TX byte source: advances just after the edge that completed a handshake.
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (tx_hs && tx_q.size() != 0) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() != 0);
            tx_data  = tx_valid ? tx_q[0] : 8'h00;
        end
    end

    function automatic apb_t wr(input logic [6:0] a, input logic [7:0] d);
        apb_t t;
        t.addr = a;
        t.wr   = 1'b1;
        t.data = d;
        return t;
    endfunction

    function automatic apb_t rd(input logic [6:0] a, input logic [7:0] d);
        apb_t t;
        t.addr = a;
        t.wr   = 1'b0;
        t.data = d;
        return t;
    endfunction

    // Queue the full expected burst. mode: empty polls per byte (0:none 1:one 2:i%3 3:three).
    task automatic plan(input int n, input logic [7:0] ss, input int mode,
                        input logic [7:0] tx0, input logic [7:0] rx0);
        apb_q.push_back(wr(7'h00, 8'h03));
        apb_q.push_back(wr(7'h1C, 8'h03));
        apb_q.push_back(wr(7'h24, ss));
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic [7:0] r;
            int         np;
            b  = (i == 0) ? tx0 : 8'($urandom);
            r  = (i == 0) ? rx0 : 8'($urandom);
            np = (mode == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? (i % 3) : 3;
            tx_q.push_back(b);
            apb_q.push_back(wr(7'h0C, b));
            for (int k = 0; k < np; k++) apb_q.push_back(rd(7'h20, 8'h04));
            apb_q.push_back(rd(7'h20, 8'hFB));
            apb_q.push_back(rd(7'h08, r));
            rx_q.push_back(r);
        end
        apb_q.push_back(wr(7'h24, 8'h00));
    endtask

    task automatic run_burst(input logic [7:0] l, input logic [7:0] ss, input int bound,
                             input int extra_at, input bit stall, input bit exp_err);
        int         d0;
        int         c;
        bit         stalled;
        logic [7:0] snap;
        d0      = done_cnt;
        stalled = 1'b0;
        @(negedge pclk);
        len       = l;
        ssel_mask = ss;
        start     = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("psel_after_start", m_psel, 1);
        check("paddr_first", m_paddr, 7'h00);
        check("err_clear_at_start", err, 0);
        c = 0;
        while (done_cnt == d0 && c < bound) begin
            if (extra_at > 0 && c == extra_at) begin
                start = 1'b1;
                len   = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (stall && !stalled && rx_valid) begin
                snap = rx_data;
                for (int k = 0; k < 10; k++) begin
                    check("stall_rx_valid", rx_valid, 1);
                    check("stall_rx_data", rx_data, snap);
                    check("stall_no_psel", m_psel, 0);
                    @(negedge pclk);
                end
                @(posedge pclk);
                #1;
                rx_ready = 1'b1;
                stalled  = 1'b1;
            end
            @(negedge pclk);
            c++;
        end
        start = 1'b0;
        repeat (3) @(negedge pclk);
        check("done_count", done_cnt - d0, 1);
        check("busy_after_done", busy, 0);
        check("err_after_burst", err, exp_err);
        check("apb_q_drained", apb_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(negedge pclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_psel", m_psel, 0);
        check("rst_paddr", m_paddr, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        aresetn = 1'b1;
        @(negedge pclk);

        // Single byte, one empty poll.
        plan(1, 8'h01, 1, 8'hA5, 8'h5A);
        run_burst(8'd1, 8'h01, 200, 0, 1'b0, 1'b0);
        check("tx_q_drained_1", tx_q.size(), 0);

        // len 0 means 256 bytes.
        plan(256, 8'h80, 2, 8'h3C, 8'hC3);
        run_burst(8'd0, 8'h80, 6000, 0, 1'b0, 1'b0);
        check("tx_q_drained_256", tx_q.size(), 0);

        // Start pulsed mid-burst is ignored.
        plan(3, 8'h04, 0, 8'h11, 8'h22);
        run_burst(8'd3, 8'h04, 300, 5, 1'b0, 1'b0);
        check("tx_q_drained_busy", tx_q.size(), 0);

        // Client back-pressure on the first received byte.
        rx_ready = 1'b0;
        plan(2, 8'h10, 1, 8'h66, 8'h99);
        run_burst(8'd2, 8'h10, 300, 0, 1'b1, 1'b0);
        rx_ready = 1'b1;

        // Asynchronous reset during a STATUS poll.
        plan(2, 8'h20, 3, 8'h77, 8'h88);
        @(negedge pclk);
        len       = 8'd2;
        ssel_mask = 8'h20;
        start     = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        c = 0;
        while (!(m_psel && m_paddr == 7'h20) && c < 200) begin
            @(negedge pclk);
            c++;
        end
        check("reached_poll", (m_psel && m_paddr == 7'h20), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_psel", m_psel, 0);
        check("arst_penable", m_penable, 0);
        check("arst_paddr", m_paddr, 0);
        check("arst_pwrite", m_pwrite, 0);
        check("arst_pwdata", m_pwdata, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_rx_data", rx_data, 0);
        check("arst_tx_ready", tx_ready, 0);
        check("arst_err", err, 0);
        apb_q.delete();
        rx_q.delete();
        tx_q.delete();
        repeat (3) @(negedge pclk);
        aresetn = 1'b1;
        repeat (3) @(negedge pclk);
        check("no_desel_after_reset", m_psel, 0);
        plan(2, 8'h08, 2, 8'hE1, 8'h1E);
        run_burst(8'd2, 8'h08, 300, 0, 1'b0, 1'b0);
        check("tx_q_drained_post_rst", tx_q.size(), 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        // STATUS stuck empty: exactly PollLimit reads, then deselect with err.
        apb_q.push_back(wr(7'h00, 8'h03));
        apb_q.push_back(wr(7'h1C, 8'h03));
        apb_q.push_back(wr(7'h24, 8'h02));
        apb_q.push_back(wr(7'h0C, 8'h3C));
        for (int k = 0; k < PollLimit; k++) apb_q.push_back(rd(7'h20, 8'h04));
        apb_q.push_back(wr(7'h24, 8'h00));
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'h44);
        tx_q.push_back(8'h55);
        run_burst(8'd3, 8'h02, 300, 0, 1'b0, 1'b1);
        check("timeout_tx_left", tx_q.size(), 2);
        tx_q.delete();
        plan(1, 8'h02, 0, 8'h5C, 8'hC5);
        run_burst(8'd1, 8'h02, 200, 0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

APB-master sequencer that drives the CoreSPI register file to run one complete master-mode SPI burst of 1–256 bytes: enable/configure, clear FIFOs, assert slave select, then one byte in flight at a time (TX write, status poll, RX read), and finally deselect. It sits between a byte-stream client (DMA or tracker logic) and the CoreSPI APB slave port, replacing CPU-driven register polling.

## Interface
- APB_DWIDTH, 8, APB data width (8/16/32); only bits [7:0] are meaningful.
- POLL_LIMIT, 255, maximum status polls per byte before timeout; used only with SPI_SEQ_TIMEOUT_EN.
- Clock and reset: one clock; reset is asynchronous and active-low.
- pclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  begin burst; sampled only in IDLE.
- len  in  8  byte count; 0 means 256. Captured at start.
- ssel_mask  in  8  slave-select value. Captured at start.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx byte accepted this cycle (valid & ready).
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid; held until rx_ready.
- rx_ready  in  1  client accepts rx_data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  timeout flag; held until next accepted start.
- m_paddr  out  7  APB address.
- m_psel, m_penable, m_pwrite  out  1 each  APB controls.
- m_pwdata  out  APB_DWIDTH  write data, upper bits zero.
- m_prdata  in  APB_DWIDTH  read data.

## Operation
- Register offsets: CTRL1 0x00, RXDATA 0x08, TXDATA 0x0C, CMD 0x1C, STATUS 0x20, SSEL 0x24. STATUS bit2 = rx_fifo_empty.
- States: IDLE → W_CTRL (CTRL1=0x03, enable+master) → W_CLR (CMD=0x03, clear both FIFOs) → W_SSEL (SSEL=ssel_mask) → TX_WAIT → W_TX (TXDATA=tx_data) → POLL (read STATUS) → R_RX (read RXDATA) → RX_OUT → (remaining>0 ? TX_WAIT : W_DESEL) ; W_DESEL (SSEL=0x00) → DONE → IDLE.
- POLL: STATUS bit2=1 → POLL again; bit2=0 → R_RX.
- TX_WAIT: tx_ready=1 combinationally while tx_valid; byte latched into m_pwdata register on handshake.
- R_RX: m_prdata[7:0] captured into rx_data in the access cycle; rx_valid set next cycle; RX_OUT leaves on rx_valid&rx_ready.
- Byte counter 9 bits, loaded with len (0→256), decremented at RX_OUT handshake; burst ends when it reaches 0.
- start while busy ignored; start in IDLE sets busy, clears err.

## Timing
- Every APB access is exactly 2 cycles: setup (psel=1, penable=0), access (psel=1, penable=1); no wait states. psel/penable low between transfers for at least one cycle only where state machine returns through a non-APB state; back-to-back transfers allowed.
- start→first m_psel: 1 cycle. Setup phase totals 6 cycles (three writes).
- Per byte minimum: TX handshake 1 + write 2 + one poll 2 + read 2 + rx output ≥1.
- DONE: done=1 for one cycle, busy drops same cycle; next start accepted the following cycle.
- Reset (any time, mid-burst included): state IDLE, all outputs 0, m_paddr 0, rx_data 0, counter 0, err 0. No deselect write is issued on reset.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined: poll counter (8 bits, cleared at W_TX) increments per STATUS read with bit2=1; on reaching POLL_LIMIT, err=1, jump to W_DESEL, then DONE; remaining tx bytes not requested.
- Undefined: POLL loops indefinitely; err tied 0; counter not implemented.

## Test plan
- len=1, ssel_mask=0x01, tx 0xA5, STATUS empty bit clears on second poll, RXDATA=0x5A -> writes 0x00←03, 0x1C←03, 0x24←01, 0x0C←A5, two STATUS reads, one RXDATA read, rx_data=0x5A, 0x24←00, done pulse.
- len=0 -> 256 TX writes and 256 rx_valid handshakes, done once.
- rx_ready held low 10 cycles -> rx_valid/rx_data stable, no APB activity until accepted.
- start pulsed while busy -> ignored, byte count unchanged.
- With SPI_SEQ_TIMEOUT_EN, POLL_LIMIT=4, STATUS bit2 stuck 1 -> exactly 4 STATUS reads, err=1, 0x24←00, done; next start clears err.
- aresetn low during POLL -> all outputs 0 asynchronously; after release new start runs full clean sequence.
